// File: rtl/result_write_buffer.sv
// result_write_buffer: FIFO for result words with frame-completion pulse;
// define RWB_OVF_FLAG_EN to add the sticky overflow flag.
module result_write_buffer #(
   parameter int DW        = 8,
   parameter int DEPTH     = 4,
   parameter int FRAME_LEN = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       wr_req,
   input  logic [DW-1:0]              wr_data,
   output logic                       full,
   output logic                       out_valid,
   output logic [DW-1:0]              out_data,
   input  logic                       out_ready,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       frame_done,
   input  logic                       ovf_clr,
   output logic                       ovf
);
   localparam int AW = $clog2(DEPTH);
   localparam int FW = FRAME_LEN > 1 ? $clog2(FRAME_LEN) : 1;
   logic [DW-1:0] mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [FW-1:0] frame_cnt;
   logic          push, pop, frame_end;
   assign full      = count == (AW+1)'(DEPTH);
   assign out_valid = count != '0;
   assign push      = wr_req && !full;
   assign pop       = out_valid && out_ready;
   assign out_data  = mem[rd_ptr];
   assign frame_end = pop && frame_cnt == FW'(FRAME_LEN-1);
   always_ff @(posedge clk)
      if (push) mem[wr_ptr] <= wr_data;
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         frame_cnt  <= '0;
         frame_done <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop) rd_ptr <= rd_ptr + AW'(1);
         count <= count + (AW+1)'(push) - (AW+1)'(pop);
         if (pop) frame_cnt <= frame_end ? '0 : frame_cnt + FW'(1);
         frame_done <= frame_end;
      end
`ifdef RWB_OVF_FLAG_EN
   // set takes priority over clear
   always_ff @(posedge clk or posedge rst)
      if (rst) ovf <= 1'b0;
      else if (wr_req && full) ovf <= 1'b1;
      else if (ovf_clr) ovf <= 1'b0;
`else
   logic unused_ovf_clr;
   assign unused_ovf_clr = ovf_clr;
   assign ovf = 1'b0;
`endif
endmodule

// File: doc/result_write_buffer.md
RESULT_WRITE_BUFFER -- requirements
Module: result_write_buffer

Interface
REQ-001 Parameter DW, default 8: width of each result word.
REQ-002 Parameter DEPTH, default 4, power of two ≥ 2: number of storage entries.
REQ-003 Parameter FRAME_LEN, default 4, ≥ 1: number of words that make up one result frame.
REQ-004 Port clk, input, 1 bit: clock; all state SHALL update on the rising edge.
REQ-005 Port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-006 Port wr_req, input, 1 bit: write request from the upstream controller shift state.
REQ-007 Port wr_data, input, DW bits: result word, sampled when wr_req=1.
REQ-008 Port full, output, 1 bit: high when count == DEPTH.
REQ-009 Port out_valid, output, 1 bit: high when count != 0.
REQ-010 Port out_data, output, DW bits: oldest stored word; valid only while out_valid=1.
REQ-011 Port out_ready, input, 1 bit: the downstream consumer accepts out_data.
REQ-012 Port count, output, log2(DEPTH)+1 bits: current occupancy.
REQ-013 Port frame_done, output, 1 bit: one-cycle pulse marking the pop that completes a frame.
REQ-014 Port ovf_clr, input, 1 bit: synchronous clear of ovf.
REQ-015 Port ovf, output, 1 bit: sticky overflow flag (see Configuration).

Function
REQ-016 A push SHALL occur when wr_req=1 and full=0 at the clock edge; wr_data is written at wr_ptr, then wr_ptr increments.
REQ-017 A pop SHALL occur when out_valid=1 and out_ready=1 at the clock edge; rd_ptr increments.
REQ-018 Pointers SHALL be log2(DEPTH) bits wide and wrap modulo DEPTH without extra logic.
REQ-019 count SHALL update as follows:
- +1 on push only
- −1 on pop only
- unchanged on simultaneous push and pop, or on neither.
REQ-020 full and out_valid SHALL be decoded from the registered count only, with no combinational path from wr_req or out_ready.
REQ-021 out_data SHALL equal the storage entry at rd_ptr, read combinationally from registered storage.
REQ-022 Latency: a word pushed at edge N SHALL appear on out_valid/out_data in the cycle after edge N; there is no bypass.
REQ-023 When full, wr_req=1 SHALL be rejected even if a pop occurs in the same cycle; storage and wr_ptr are unchanged.
REQ-024 When empty, simultaneous wr_req and out_ready SHALL result in a push only.
REQ-025 A frame counter SHALL increment on each pop and wrap to 0 after FRAME_LEN pops.
REQ-026 frame_done SHALL be registered and high for exactly the one cycle after the edge of the FRAME_LEN-th pop.
REQ-027 Order SHALL be strictly first-in, first-out; no word is duplicated or reordered.

Reset
REQ-028 While rst=1, the following SHALL be held at zero:
- wr_ptr, rd_ptr, count, frame counter
- frame_done, ovf
- and therefore full=0, out_valid=0.
REQ-029 An assertion of rst mid-operation SHALL discard all stored words and any partial frame.
REQ-030 Storage contents need not be reset; out_data is don't-care while out_valid=0.

Configuration
REQ-031 Macro RWB_OVF_FLAG_EN, when defined:
- ovf SHALL set on any edge with wr_req=1 and full=1
- ovf SHALL stay set until ovf_clr=1 or rst.
- If set and clear coincide, set wins.
REQ-032 Macro RWB_OVF_FLAG_EN, when not defined:
- ovf SHALL be tied to 0
- ovf_clr SHALL be ignored
- no overflow register is instantiated.

Verification
REQ-033 Single word: after reset, push 0xA5 with out_ready=0. The next cycle SHALL show out_valid=1, out_data=0xA5, count=1; one pop then SHALL return count=0, out_valid=0.
REQ-034 Fill and order: push 0x11, 0x22, 0x33, 0x44 with out_ready=0, giving full=1 and count=4. Then hold out_ready=1: data SHALL be 0x11, 0x22, 0x33, 0x44 in order, and frame_done SHALL pulse once, after the 4th pop.
REQ-035 Overflow (RWB_OVF_FLAG_EN defined): while full, wr_req with 0x55 SHALL leave storage unchanged and set ovf=1; ovf_clr SHALL then return ovf to 0. With the macro undefined, ovf SHALL stay 0.
REQ-036 Full with simultaneous push and pop: count SHALL go 4→3, and 0x66 SHALL be dropped (never output).
REQ-037 Wrap and streaming: 10 consecutive wr_req with out_ready=1 and data 1..10 SHALL give:
- output 1..10 in order
- count ≤ 1 throughout
- frame_done pulses after pops 4 and 8.
REQ-038 Reset mid-frame: with 3 words stored and 2 popped, asserting rst SHALL give count=0 and out_valid=0. A subsequent frame SHALL need 4 fresh pops before frame_done pulses.
